// File: rtl/bus_grant_mux_pkg.sv
// Shared definitions for the bus grant mux: the arbiter grant codes, the FSM
// state encoding, the default bus widths and the grant-to-ack decode.
package bus_grant_mux_pkg;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 8;

  // Grant codes are shared with the upstream arbiter, so the values are fixed.
  typedef enum logic [1:0] {
    GNT_A    = 2'b00,
    GNT_B    = 2'b01,
    GNT_C    = 2'b10,
    GNT_NONE = 2'b11
  } grant_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // One-hot ack vector {C, B, A} for a given owner; no owner gives no ack.
  function automatic logic [2:0] owner_onehot(grant_e g);
    case (g)
      GNT_A:   return 3'b001;
      GNT_B:   return 3'b010;
      GNT_C:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter for the command phase; flags the last cycle the slave is
// given to respond before the transaction completes with an error.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 15,
  parameter int CW      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  logic [CW-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement or process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_grant_mux.sv
// Routes the arbiter-granted master onto the shared slave bus, runs one
// transaction to completion (ready or timeout) and returns ack/rdata/err.
module bus_grant_mux
  import bus_grant_mux_pkg::*;
#(
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    grant,
  input  logic          valid_a,
  input  logic          valid_b,
  input  logic          valid_c,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [AW-1:0] addr_c,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  input  logic [DW-1:0] wdata_c,
  input  logic          we_a,
  input  logic          we_b,
  input  logic          we_c,
  output logic          bus_sel,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_we,
  input  logic          bus_ready,
  input  logic [DW-1:0] bus_rdata,
  output logic          ack_a,
  output logic          ack_b,
  output logic          ack_c,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy
);

  state_e        state_q, state_d;
  grant_e        owner_q, owner_d;
  logic          sel_q, sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [2:0]    ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic          src_valid;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_wdata;
  logic          src_we;

  logic          ctr_clear, ctr_en, ctr_term;

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CW      (8)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ctr_clear),
    .en       (ctr_en),
    .terminal (ctr_term)
  );

  // 3:1 source mux; GNT_NONE yields src_valid=0 so IDLE never starts.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    src_valid = 1'b0;
    src_addr  = '0;
    src_wdata = '0;
    src_we    = 1'b0;
    case (grant_e'(grant))
      GNT_A: begin
        src_valid = valid_a;
        src_addr  = addr_a;
        src_wdata = wdata_a;
        src_we    = we_a;
      end
      GNT_B: begin
        src_valid = valid_b;
        src_addr  = addr_b;
        src_wdata = wdata_b;
        src_we    = we_b;
      end
      GNT_C: begin
        src_valid = valid_c;
        src_addr  = addr_c;
        src_wdata = wdata_c;
        src_we    = we_c;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    ack_d     = ack_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    busy_d    = busy_q;
    ctr_clear = 1'b0;
    ctr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (src_valid) begin
          owner_d   = grant_e'(grant);
          addr_d    = src_addr;
          wdata_d   = src_wdata;
          we_d      = src_we;
          sel_d     = 1'b1;
          busy_d    = 1'b1;
          ctr_clear = 1'b1;
          state_d   = ST_CMD;
        end
      end
      ST_CMD: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (bus_ready) begin
          sel_d   = 1'b0;
          err_d   = 1'b0;
          ack_d   = owner_onehot(owner_q);
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = bus_rdata;
          end
        end else if (ctr_term) begin
          sel_d   = 1'b0;
          err_d   = 1'b1;
          ack_d   = owner_onehot(owner_q);
          state_d = ST_DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ST_DONE: begin
        ack_d   = 3'b000;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= GNT_NONE;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack_q   <= 3'b000;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;
  assign ack_a     = ack_q[0];
  assign ack_b     = ack_q[1];
  assign ack_c     = ack_q[2];
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_grant_mux.sv
// Self-checking bench for bus_grant_mux: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bus_grant_mux;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    grant;
  logic          valid_a, valid_b, valid_c;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [DW-1:0] wdata_a, wdata_b, wdata_c;
  logic          we_a, we_b, we_c;
  logic          bus_sel;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_we;
  logic          bus_ready;
  logic [DW-1:0] bus_rdata;
  logic          ack_a, ack_b, ack_c;
  logic [DW-1:0] rdata;
  logic          err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  bus_grant_mux #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .grant     (grant),
    .valid_a   (valid_a),
    .valid_b   (valid_b),
    .valid_c   (valid_c),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .addr_c    (addr_c),
    .wdata_a   (wdata_a),
    .wdata_b   (wdata_b),
    .wdata_c   (wdata_c),
    .we_a      (we_a),
    .we_b      (we_b),
    .we_c      (we_c),
    .bus_sel   (bus_sel),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .ack_c     (ack_c),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: a transaction is "open" from its start until
  // the cycle after it completes; age counts command cycles without ready.
  bit            m_open, m_closing;
  int            m_age, m_owner;
  logic          e_sel, e_we, e_err, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [2:0]    e_ack;

  always @(posedge clk) begin
    logic          v[3];
    logic [AW-1:0] a[3];
    logic [DW-1:0] d[3];
    logic          w[3];
    v = '{valid_a, valid_b, valid_c};
    a = '{addr_a, addr_b, addr_c};
    d = '{wdata_a, wdata_b, wdata_c};
    w = '{we_a, we_b, we_c};
    if (!rst_n) begin
      m_open = 0; m_closing = 0; m_age = 0;
      e_sel = 0; e_we = 0; e_err = 0; e_busy = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0; e_ack = '0;
    end else if (m_closing) begin
      m_open = 0; m_closing = 0;
      e_ack = '0; e_err = 0; e_busy = 0;
    end else if (m_open) begin
      m_age++;
      if (bus_ready || m_age == TIMEOUT) begin
        e_sel = 0;
        e_err = !bus_ready;
        e_ack = 3'b000;
        e_ack[m_owner] = 1'b1;
        if (bus_ready && !e_we) e_rdata = bus_rdata;
        m_closing = 1;
      end
    end else if (grant != 2'b11 && v[grant]) begin
      m_owner = int'(grant);
      e_addr = a[grant]; e_wdata = d[grant]; e_we = w[grant];
      e_sel = 1; e_busy = 1; m_open = 1; m_age = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model bus_sel", bus_sel, e_sel);
      check("model busy", busy, e_busy);
      check("model ack", {ack_c, ack_b, ack_a}, e_ack);
      check("model err", err, e_err);
      check("model rdata", rdata, e_rdata);
      check("model bus_addr", bus_addr, e_addr);
      check("model bus_wdata", bus_wdata, e_wdata);
      check("model bus_we", bus_we, e_we);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst_n = 0; grant = 2'b00; bus_ready = 0; bus_rdata = 8'h11;
    valid_a = 1; valid_b = 0; valid_c = 0;
    addr_a = 8'h77; addr_b = 8'h00; addr_c = 8'h00;
    wdata_a = 8'h01; wdata_b = 8'h00; wdata_c = 8'h00;
    we_a = 0; we_b = 0; we_c = 0;
    @(posedge clk);
    chk_en = 1;

    // 1: reset with a pending request, then release
    tick(); tick();
    check("rst bus_sel", bus_sel, 0);
    check("rst busy", busy, 0);
    check("rst outputs", {ack_a, ack_b, ack_c, err, rdata}, 0);
    rst_n = 1;
    tick();
    check("post-rst bus_sel", bus_sel, 1);
    bus_ready = 1; valid_a = 0;
    tick(); tick();
    bus_ready = 0;
    tick();

    // 2: read by B, ready two cycles after bus_sel
    grant = 2'b01; valid_b = 1; addr_b = 8'h3C; we_b = 0;
    tick();
    check("B sel", bus_sel, 1);
    check("B addr", bus_addr, 8'h3C);
    check("B we", bus_we, 0);
    tick();
    bus_ready = 1; bus_rdata = 8'hA5;
    tick();
    check("B ack", {ack_c, ack_b, ack_a}, 3'b010);
    check("B rdata", rdata, 8'hA5);
    check("B err", err, 0);
    valid_b = 0; bus_ready = 0; bus_rdata = 8'hEE;
    tick();
    check("B ack drop", ack_b, 0);
    check("B busy drop", busy, 0);

    // 3: write by C, grant moves to A mid-transaction
    grant = 2'b10; valid_c = 1; addr_c = 8'h10; wdata_c = 8'h5A; we_c = 1; valid_a = 1;
    tick();
    grant = 2'b00;
    tick(); tick();
    check("C held", {bus_sel, bus_addr, bus_wdata, bus_we}, {1'b1, 8'h10, 8'h5A, 1'b1});
    bus_ready = 1;
    tick();
    check("C ack", {ack_c, ack_b, ack_a}, 3'b100);
    valid_c = 0; bus_ready = 0;
    tick();
    check("A not yet", bus_sel, 0);
    tick();
    check("A start", {bus_sel, bus_addr}, {1'b1, 8'h77});

    // 4: timeout on A's read
    cnt = 0;
    while (bus_sel && cnt < 40) begin
      cnt++;
      tick();
    end
    check("timeout sel cycles", cnt, 15);
    check("timeout ack/err", {ack_a, err}, 2'b11);
    check("timeout rdata", rdata, 8'hA5);
    valid_a = 0; grant = 2'b11;
    tick();
    check("timeout clear", {ack_a, err, busy}, 3'b000);

    // 5: no grant, stray ready ignored
    valid_a = 1; valid_b = 1; valid_c = 1; bus_ready = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("nogrant sel/busy", {bus_sel, busy}, 2'b00);
    end
    valid_a = 0; valid_b = 0; valid_c = 0; bus_ready = 0;
    tick();

    // 6: reset during CMD, then a fresh write by B
    grant = 2'b01; valid_b = 1; addr_b = 8'h42; wdata_b = 8'h99; we_b = 1;
    tick();
    check("B2 sel", bus_sel, 1);
    tick();
    rst_n = 0;
    tick();
    check("midrst", {bus_sel, ack_b, busy}, 3'b000);
    rst_n = 1;
    tick();
    check("B3 start", {bus_sel, bus_addr, bus_we}, {1'b1, 8'h42, 1'b1});
    bus_ready = 1;
    tick();
    check("B3 ack", {ack_b, err}, 2'b10);
    check("B3 rdata", rdata, 8'h00);
    valid_b = 0; bus_ready = 0; grant = 2'b11;
    tick(); tick();

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_grant_mux.md
Name: bus_grant_mux

Overview:
- Downstream stage of the three-requester bus arbiter.
- Consumes the arbiter's registered 2-bit grant code and routes the granted master's (A/B/C) transaction onto the single shared slave bus.
- Runs one transaction to completion with a ready handshake and a timeout, then returns ack, read data and error to the owning master.
- Exports busy so the system can hold requests stable while a transaction is in flight.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- TIMEOUT, 15, maximum CMD cycles to wait for slave ready before an error completion (1..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- grant  in  2  arbiter code: 00=A, 01=B, 10=C, 11=no grant.
- valid_a/valid_b/valid_c  in  1 each  master has a transaction pending.
- addr_a/addr_b/addr_c  in  AW each  master address.
- wdata_a/wdata_b/wdata_c  in  DW each  master write data.
- we_a/we_b/we_c  in  1 each  1=write, 0=read.
- bus_sel  out  1  slave strobe.
- bus_addr  out  AW  slave address.
- bus_wdata  out  DW  slave write data.
- bus_we  out  1  slave write enable.
- bus_ready  in  1  slave completion.
- bus_rdata  in  DW  slave read data.
- ack_a/ack_b/ack_c  out  1 each  one-cycle completion pulse to owner.
- rdata  out  DW  read data returned to owner.
- err  out  1  qualifies ack; 1 = timeout.
- busy  out  1  transaction in flight (CMD or DONE).

Behaviour:
- Reset is synchronous: when rst_n=0 at a clock edge, all outputs go to 0, the FSM goes to IDLE, the owner register becomes 11 and the timeout counter becomes 0. Reset takes effect mid-transaction with no ack issued.
- All outputs are registered.

FSM states: IDLE, CMD, DONE.

IDLE:
- If grant != 11 and the granted master's valid=1: latch owner=grant, latch that master's addr/wdata/we onto bus_addr/bus_wdata/bus_we, set bus_sel=1, busy=1, clear the counter, go to CMD.
- If grant=11, or the granted master's valid=0: stay in IDLE. Other masters' valid is ignored.

CMD:
- bus_sel, bus_addr, bus_wdata and bus_we are held constant.
- grant and valid changes are ignored (owner is locked).
- If bus_ready=1: bus_sel goes to 0. If bus_we=0, rdata is loaded with bus_rdata; if bus_we=1, rdata keeps its previous value. err goes to 0, ack[owner] goes to 1, and the FSM goes to DONE.
- Else, when the counter = TIMEOUT-1: bus_sel goes to 0, err goes to 1, ack[owner] goes to 1, rdata is unchanged, and the FSM goes to DONE.
- Else the counter increments.

DONE:
- Lasts exactly one cycle.
- ack deasserts and err clears at its end. busy goes to 0 and the FSM returns to IDLE.
- grant and valid are not sampled in DONE.

Timing:
- Latency: request sampled at edge N; bus_sel high from N+1.
- bus_ready seen at edge M gives ack high during the cycle after M.
- Minimum turnaround: 3 cycles per transaction, so back-to-back transactions start at most every 3 cycles.

Boundary conditions:
- Only one ack is ever high at a time, and only while in DONE.
- bus_ready while not in CMD is ignored.
- bus_ready=1 on the timeout cycle: ready wins and err=0.
- A master must drop valid on seeing ack; otherwise it is re-serviced if still granted.

Decomposition:
- Shared package holds:
  - grant codes GNT_A=2'b00, GNT_B=2'b01, GNT_C=2'b10, GNT_NONE=2'b11 (shared with the arbiter);
  - FSM state encoding ST_IDLE/ST_CMD/ST_DONE;
  - default AW/DW.
- One natural sub-module: bus_timeout_ctr (load/clear, enable, terminal flag at TIMEOUT-1).
- The 3:1 source mux stays inline.

Test Plan:
1. Reset: rst_n=0 for 2 cycles, with grant=00 and valid_a=1 -> all outputs 0, busy=0, no bus_sel. Release -> bus_sel rises 1 cycle later.
2. Read by B: grant=01, valid_b=1, addr_b=8'h3C, we_b=0; slave ready 2 cycles after bus_sel with bus_rdata=8'hA5 -> bus_addr=3C and bus_we=0 while sel is high; ack_b pulses 1 cycle with rdata=A5, err=0; ack_a=ack_c=0.
3. Write by C with grant changing mid-transaction: grant=10, valid_c=1, addr_c=8'h10, wdata_c=8'h5A, we_c=1; grant switches to 00 during CMD -> bus stays addr 10 / data 5A / we=1 until ready; ack_c pulses; A is not serviced until IDLE is re-entered.
4. Timeout: grant=00, valid_a=1, bus_ready held 0 -> bus_sel high exactly 15 cycles; ack_a and err both high for 1 cycle; rdata unchanged.
5. No grant: grant=11 with all valid=1 for 10 cycles -> bus_sel=0 and busy=0 throughout.
6. Reset during CMD: assert rst_n=0 while bus_sel=1 -> next edge bus_sel=0, no ack; after release with grant=01 and valid_b=1, a fresh transaction starts normally.
